// File: rtl/compress_stage2_iter_if.sv
// rtl/compress_stage2_iter_if.sv - bus bundle between stage1, stage2 and the digest consumer
// Direction names are from stage2's point of view (_i into stage2, _o out of it).
interface compress_stage2_iter_if #(
  parameter int NUM_PAIRS = 32,
  parameter int IDX_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
);
  logic             start_i;
  logic [255:0]     hin_i;
  logic             busy_o;
  logic [IDX_W-1:0] pair_idx_o;
  logic             w_valid_i;
  logic [255:0]     state_o;
  logic [31:0]      p1_i;
  logic [31:0]      p2_i;
  logic [31:0]      p3_i;
  logic [31:0]      p4_i;
  logic [31:0]      p5_i;
  logic [31:0]      a_dash_i;
  logic [31:0]      b_dash_i;
  logic [31:0]      e_dash_i;
  logic [31:0]      f_dash_i;
  logic [255:0]     digest_o;
  logic             digest_valid_o;
  logic             digest_ready_i;

  modport master (
    output start_i, hin_i, w_valid_i, digest_ready_i,
    output p1_i, p2_i, p3_i, p4_i, p5_i,
    output a_dash_i, b_dash_i, e_dash_i, f_dash_i,
    input  busy_o, pair_idx_o, state_o, digest_o, digest_valid_o
  );

  modport slave (
    input  start_i, hin_i, w_valid_i, digest_ready_i,
    input  p1_i, p2_i, p3_i, p4_i, p5_i,
    input  a_dash_i, b_dash_i, e_dash_i, f_dash_i,
    output busy_o, pair_idx_o, state_o, digest_o, digest_valid_o
  );
endinterface

// File: rtl/compress_stage2_iter.sv
// rtl/compress_stage2_iter.sv - SHA-256 two-rounds-per-cycle back end with digest hand-off
// Finishes both rounds of a K/W pair from stage1's precomputed sums, then adds the chaining value.
module compress_stage2_iter #(
  parameter int NUM_PAIRS = 32,
  parameter int IDX_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input logic                   clk,
  input logic                   rst_n,
  compress_stage2_iter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ADD  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  state_e           state_q, state_d;
  logic [255:0]     work_q, work_d;
  logic [255:0]     hsave_q, hsave_d;
  logic [255:0]     digest_q, digest_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_pair;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Second round reuses S1/ch of the first round's e, shared between u and e2.
  logic [31:0] a1, e1, s1_e1, ch_e1, u, a2, e2;

  always_comb begin
    a1    = bus.p1_i + bus.p3_i;
    e1    = bus.p2_i;
    s1_e1 = big_s1(e1);
    ch_e1 = ch(e1, bus.e_dash_i, bus.f_dash_i);
    u     = bus.p4_i + s1_e1 + ch_e1;
    a2    = u + big_s0(a1) + maj(a1, bus.a_dash_i, bus.b_dash_i);
    e2    = bus.p5_i + s1_e1 + ch_e1;
  end

  assign last_pair = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_RUN;
      ST_RUN:  if (bus.w_valid_i && last_pair) state_d = ST_ADD;
      ST_ADD:  state_d = ST_HOLD;
      ST_HOLD: if (bus.digest_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    work_d   = work_q;
    hsave_d  = hsave_q;
    digest_d = digest_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          work_d  = bus.hin_i;
          hsave_d = bus.hin_i;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (bus.w_valid_i) begin
          work_d = {a2, a1, bus.a_dash_i, bus.b_dash_i,
                    e2, e1, bus.e_dash_i, bus.f_dash_i};
          idx_d  = last_pair ? '0 : idx_q + IDX_W'(1);
        end
      end
      ST_ADD: begin
        for (int j = 0; j < 8; j++) begin
          digest_d[32*j +: 32] = hsave_q[32*j +: 32] + work_q[32*j +: 32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q   <= '0;
      hsave_q  <= '0;
      digest_q <= '0;
      idx_q    <= '0;
    end else begin
      work_q   <= work_d;
      hsave_q  <= hsave_d;
      digest_q <= digest_d;
      idx_q    <= idx_d;
    end
  end

  // Valid is exactly "in HOLD", so it drops on the handshake edge with the return to IDLE.
  always_comb begin
    bus.busy_o         = (state_q != ST_IDLE);
    bus.digest_valid_o = (state_q == ST_HOLD);
  end

  assign bus.state_o    = work_q;
  assign bus.pair_idx_o = idx_q;
  assign bus.digest_o   = digest_q;

endmodule

// File: tb/tb_compress_stage2_iter.sv
// tb/tb_compress_stage2_iter.sv - bench for compress_stage2_iter with a stage1 stand-in
// Expected states and digests come from a plain one-round-at-a-time SHA-256 model.
module tb_compress_stage2_iter;
  localparam int NP = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic [31:0] w_sched [64];
  logic [31:0] junk;

  compress_stage2_iter_if #(.NUM_PAIRS(NP)) intf ();

  compress_stage2_iter #(.NUM_PAIRS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One textbook SHA-256 round; kw is K[t]+W[t].
  function automatic logic [255:0] sha_round(input logic [255:0] st, input logic [31:0] kw);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = st;
    t1 = h + bs1(e) + ((e & f) ^ (~e & g)) + kw;
    t2 = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sha_ref(input logic [255:0] h);
    logic [255:0] st;
    st = h;
    for (int t = 0; t < 64; t++) st = sha_round(st, k_tab[t] + w_sched[t]);
    return add8(h, st);
  endfunction

  task automatic load_sched(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w_sched[t] = blk[511-32*t -: 32];
      else w_sched[t] = ss1(w_sched[t-2]) + w_sched[t-7] + ss0(w_sched[t-15]) + w_sched[t-16];
    end
  endtask

  // Stage1 stand-in: precompute sums from state_o for pair index n; junk on stall cycles.
  always_comb begin
    logic [31:0] a, b, c, d, e, f, g, h, t1, kw2;
    int i;
    {a, b, c, d, e, f, g, h} = intf.state_o;
    i   = 2 * int'(intf.pair_idx_o);
    t1  = h + bs1(e) + ((e & f) ^ (~e & g)) + k_tab[i] + w_sched[i];
    kw2 = g + k_tab[i+1] + w_sched[i+1];
    if (intf.w_valid_i) begin
      intf.p1_i = t1;
      intf.p2_i = d + t1;
      intf.p3_i = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
      intf.p4_i = kw2;
      intf.p5_i = c + kw2;
      intf.a_dash_i = a;
      intf.b_dash_i = b;
      intf.e_dash_i = e;
      intf.f_dash_i = f;
    end else begin
      intf.p1_i = junk;
      intf.p2_i = ~junk;
      intf.p3_i = junk ^ 32'h5a5a5a5a;
      intf.p4_i = junk + 32'd1;
      intf.p5_i = junk - 32'd7;
      intf.a_dash_i = rotr(junk, 3);
      intf.b_dash_i = rotr(junk, 9);
      intf.e_dash_i = rotr(junk, 17);
      intf.f_dash_i = rotr(junk, 29);
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // stall_mode: 0 none, 1 every third RUN cycle, >=2 random stall percentage.
  task automatic run_block(input logic [255:0] h, input logic [511:0] blk, input int stall_mode,
                           input int ready_delay, input int start_at, input int rst_at,
                           output logic [255:0] dig);
    logic [255:0] ms, exp_dig;
    int pairs, run_cyc, stalls, lat;
    logic wv, pulsed;
    dig = '0;
    load_sched(blk);
    ms = h;
    exp_dig = sha_ref(h);
    intf.hin_i = h;
    intf.start_i = 1'b1;
    @(posedge clk); #1;
    intf.start_i = 1'b0;
    check("start_busy", intf.busy_o, 1);
    check("start_idx", intf.pair_idx_o, 0);
    check("start_state", intf.state_o, h);
    pairs = 0; run_cyc = 0; stalls = 0; pulsed = 1'b0;
    while (pairs < NP && run_cyc < 200) begin
      if (rst_at == pairs) begin
        rst_n = 1'b0;
        intf.w_valid_i = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        intf.w_valid_i = 1'b0;
        check("rst_state", intf.state_o, 0);
        check("rst_digest", intf.digest_o, 0);
        check("rst_valid", intf.digest_valid_o, 0);
        check("rst_busy", intf.busy_o, 0);
        check("rst_idx", intf.pair_idx_o, 0);
        return;
      end
      if (stall_mode == 0) wv = 1'b1;
      else if (stall_mode == 1) wv = (run_cyc % 3) != 2;
      else wv = $urandom_range(99) >= stall_mode;
      intf.w_valid_i = wv;
      junk = $urandom;
      if (start_at == pairs && !pulsed) begin
        intf.start_i = 1'b1;
        intf.hin_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pulsed = 1'b1;
      end
      @(posedge clk); #1;
      intf.start_i = 1'b0;
      intf.hin_i = h;
      run_cyc++;
      if (wv) begin
        ms = sha_round(ms, k_tab[2*pairs] + w_sched[2*pairs]);
        ms = sha_round(ms, k_tab[2*pairs+1] + w_sched[2*pairs+1]);
        pairs++;
      end else begin
        stalls++;
      end
      check("pair_state", intf.state_o, ms);
      check("pair_idx", intf.pair_idx_o, pairs % NP);
    end
    intf.w_valid_i = 1'b0;
    check("pairs_done", pairs, NP);
    check("add_valid_low", intf.digest_valid_o, 0);
    lat = run_cyc;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!intf.digest_valid_o && lat < run_cyc + 4);
    check("latency", lat, NP + 1 + stalls);
    check("digest", intf.digest_o, exp_dig);
    dig = intf.digest_o;
    for (int d = 0; d < ready_delay; d++) begin
      intf.start_i = (d == 0);
      intf.w_valid_i = 1'b1;
      junk = $urandom;
      @(posedge clk); #1;
      intf.start_i = 1'b0;
      check("hold_valid", intf.digest_valid_o, 1);
      check("hold_busy", intf.busy_o, 1);
      check("hold_digest", intf.digest_o, exp_dig);
      check("hold_state", intf.state_o, ms);
    end
    intf.w_valid_i = 1'b0;
    intf.digest_ready_i = 1'b1;
    @(posedge clk); #1;
    intf.digest_ready_i = 1'b0;
    check("hs_valid", intf.digest_valid_o, 0);
    check("hs_busy", intf.busy_o, 0);
    if (ready_delay > 0) begin
      @(posedge clk); #1;
      check("no_queued_start", intf.busy_o, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] dig, d1, h;
    logic [511:0] blk;
    logic [511:0] abc_blk;
    logic [447:0] msg56;
    abc_blk = {24'h616263, 8'h80, 416'h0, 64'd24};
    msg56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

    // Reset wins even with start_i asserted.
    intf.start_i = 1'b1;
    intf.hin_i = IV;
    intf.w_valid_i = 1'b0;
    intf.digest_ready_i = 1'b0;
    junk = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    intf.start_i = 1'b0;
    check("reset_busy", intf.busy_o, 0);
    check("reset_idx", intf.pair_idx_o, 0);
    check("reset_valid", intf.digest_valid_o, 0);
    check("reset_state", intf.state_o, 0);
    check("reset_digest", intf.digest_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", intf.busy_o, 0);

    run_block(IV, abc_blk, 0, 0, -1, -1, dig);
    check("abc_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    run_block(IV, {8'h80, 440'h0, 64'h0}, 1, 0, -1, -1, dig);
    check("empty_digest", dig, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

    run_block(IV, abc_blk, 0, 10, -1, -1, dig);
    check("bp_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    run_block(IV, abc_blk, 0, 0, 5, -1, dig);
    check("start_ignored_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    run_block(IV, abc_blk, 0, 0, -1, 17, dig);
    run_block(IV, abc_blk, 0, 0, -1, -1, dig);
    check("post_rst_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    run_block(IV, {msg56, 8'h80, 56'h0}, 0, 0, -1, -1, d1);
    run_block(d1, {448'h0, 64'd448}, 2, 1, -1, -1, dig);
    check("two_block_digest", dig, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

    for (int r = 0; r < 6; r++) begin
      h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
      run_block(h, blk, 25, int'($urandom_range(0, 3)), -1, -1, dig);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
